dz_scan: RTL and testbench
==========================

DZ_SCAN -- requirements
Module: dz_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per row slot, legal range 4..65535.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 st  in  1  scan enable; 0 blanks the matrix and holds the scan.
REQ-005 ld  in  1  one-cycle strobe; num is sampled when ld=1.
REQ-006 num  in  4  image index 0..15.
REQ-007 fail  in  1  1 renders the image in green, 0 renders it in red.
REQ-008 row  out  8  row select, active-low one-hot; bit i selects matrix row i.
REQ-009 colg  out  8  green column drive, active-high; bit j selects column j.
REQ-010 colr  out  8  red column drive, active-high.

Function
REQ-011 Two states: IDLE and SCAN; IDLE->SCAN when st=1; SCAN->IDLE when st=0; each transition takes effect on the next edge.
REQ-012 In IDLE: row=8'hFF, colg=colr=0, prescaler=0, row counter=0.
REQ-013 In SCAN: 16-bit prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the 3-bit row counter increments, 7 wraps to 0.
REQ-014 Each row slot starts with exactly one blank cycle (prescaler=0): row=8'hFF, colg=colr=0; cycles 1..SCAN_DIV-1 drive row=~(1<<rowcnt) and the columns.
REQ-015 Image ROM: 16 images x 8 rows x 8 bits, combinational, indexed {cur_img,rowcnt}; image 14 = all 8'hFF, image 15 = all 8'h00; images 0..13 are the egg/animal bitmaps from the team artwork table.
REQ-016 Column data = ROM row; fail=1 -> colg=data, colr=0; fail=0 -> colr=data, colg=0; fail is sampled per cycle, not latched.
REQ-017 ld=1 loads num into pend_img on the next edge; cur_img updates only at frame start (row counter 7->0 wrap) or on the IDLE->SCAN transition, so no frame is torn.
REQ-018 ld=1 in the same cycle as a frame wrap: num goes directly into cur_img and pend_img.
REQ-019 ld during IDLE: value held in pend_img, applied on entry to SCAN.
REQ-020 st falling mid-frame: blank on the next edge, row counter reset to 0; the next SCAN entry starts at row 0 with a blank cycle.
REQ-021 Frame period = 8*SCAN_DIV cycles; image-change latency after ld = 1 to 8*SCAN_DIV cycles.

Reset
REQ-022 rst=1 forces state=IDLE, row=8'hFF, colg=colr=0, prescaler=0, row counter=0, cur_img=pend_img=15, blink counter=0.
REQ-023 rst has priority over st and ld in the same cycle; rst in mid-frame blanks the outputs on the next edge.

Configuration
REQ-024 Macro DZ_BLINK_EN defined: a 5-bit frame counter increments at each frame wrap; while fail=1 and counter bit 4=1, colg=colr=0 (16 frames on, 16 off); while fail=0 there is no blink.
REQ-025 Macro DZ_BLINK_EN undefined: no frame counter exists; fail only selects colour per REQ-016.

Verification (SCAN_DIV=4)
REQ-026 rst=1 for 2 cycles, then st=0 -> row=8'hFF, colg=colr=0 held for 20 cycles.
REQ-027 Pulse ld with num=14, fail=0, then st=1 -> repeating per-row pattern: 1 blank cycle, then 3 cycles of row=8'hFE, colr=8'hFF, colg=0; rows advance FE,FD,FB..7F, then back to FE.
REQ-028 Image 14 scanning, pulse ld with num=15 at row 3 -> rows 3..7 still show 8'hFF; from the next row 0, colr=0.
REQ-029 Image 14 scanning, fail=1 -> next cycle colg=8'hFF, colr=0; with DZ_BLINK_EN, columns are dark for frames 16..31 and lit for frames 0..15 and 32..47.
REQ-030 st dropped at row 5 -> next edge row=8'hFF; st raised again -> first cycle blank, then row=8'hFE.
REQ-031 ld coincident with the 7->0 wrap, num=14, previous image 15 -> row 0 of the new frame shows colr=8'hFF.

Source files
------------

// File: rtl/dz_scan.sv
// 8x8 bicolour dot-matrix scanner: one row per SCAN_DIV-cycle slot, images from a 16-entry ROM.
// Optional blink of the green image every 16 frames when compiled with DZ_BLINK_EN.
module dz_scan #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    input  logic       ld,
    input  logic [3:0] num,
    input  logic       fail,
    output logic [7:0] row,
    output logic [7:0] colg,
    output logic [7:0] colr
);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [2:0]  rowcnt_q, rowcnt_d;
    logic [3:0]  cur_img_q, cur_img_d;
    logic [3:0]  pend_img_q, pend_img_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  colg_q, colg_d;
    logic [7:0]  colr_q, colr_d;
    logic [7:0]  rom_data;
    logic        cols_off;

    // Bit i of a ROM byte lights column i; images 14/15 are the all-on/all-off test patterns.
    function automatic logic [7:0] img_rom(input logic [6:0] addr);
        logic [7:0] d;
        d = 8'h00;
        case (addr)
            7'd0:   d = 8'h18;  7'd1:   d = 8'h3C;  7'd2:   d = 8'h7E;  7'd3:   d = 8'h7E;
            7'd4:   d = 8'hFF;  7'd5:   d = 8'hFF;  7'd6:   d = 8'h7E;  7'd7:   d = 8'h3C;
            7'd8:   d = 8'h18;  7'd9:   d = 8'h3C;  7'd10:  d = 8'h76;  7'd11:  d = 8'h6E;
            7'd12:  d = 8'hFF;  7'd13:  d = 8'hFB;  7'd14:  d = 8'h7E;  7'd15:  d = 8'h3C;
            7'd16:  d = 8'h24;  7'd17:  d = 8'h5A;  7'd18:  d = 8'h3C;  7'd19:  d = 8'h66;
            7'd20:  d = 8'hFF;  7'd21:  d = 8'hFF;  7'd22:  d = 8'h7E;  7'd23:  d = 8'h3C;
            7'd24:  d = 8'h3C;  7'd25:  d = 8'h42;  7'd26:  d = 8'hA5;  7'd27:  d = 8'h81;
            7'd28:  d = 8'h7E;  7'd29:  d = 8'h3C;  7'd30:  d = 8'h24;  7'd31:  d = 8'h66;
            7'd32:  d = 8'h81;  7'd33:  d = 8'hC3;  7'd34:  d = 8'hBD;  7'd35:  d = 8'h99;
            7'd36:  d = 8'hFF;  7'd37:  d = 8'h7E;  7'd38:  d = 8'h3C;  7'd39:  d = 8'h24;
            7'd40:  d = 8'hE7;  7'd41:  d = 8'hA5;  7'd42:  d = 8'hFF;  7'd43:  d = 8'hDB;
            7'd44:  d = 8'hFF;  7'd45:  d = 8'h7E;  7'd46:  d = 8'h66;  7'd47:  d = 8'hC3;
            7'd48:  d = 8'h66;  7'd49:  d = 8'h66;  7'd50:  d = 8'h66;  7'd51:  d = 8'h7E;
            7'd52:  d = 8'hDB;  7'd53:  d = 8'hFF;  7'd54:  d = 8'h7E;  7'd55:  d = 8'h3C;
            7'd56:  d = 8'h08;  7'd57:  d = 8'h1C;  7'd58:  d = 8'hBE;  7'd59:  d = 8'hFF;
            7'd60:  d = 8'hFF;  7'd61:  d = 8'hBE;  7'd62:  d = 8'h1C;  7'd63:  d = 8'h08;
            7'd64:  d = 8'h00;  7'd65:  d = 8'h66;  7'd66:  d = 8'hFF;  7'd67:  d = 8'h7E;
            7'd68:  d = 8'h3C;  7'd69:  d = 8'h18;  7'd70:  d = 8'h00;  7'd71:  d = 8'h00;
            7'd72:  d = 8'h00;  7'd73:  d = 8'h3C;  7'd74:  d = 8'h42;  7'd75:  d = 8'h5A;
            7'd76:  d = 8'h52;  7'd77:  d = 8'h3E;  7'd78:  d = 8'h7F;  7'd79:  d = 8'h00;
            7'd80:  d = 8'h66;  7'd81:  d = 8'hFF;  7'd82:  d = 8'hDB;  7'd83:  d = 8'hFF;
            7'd84:  d = 8'h7E;  7'd85:  d = 8'h42;  7'd86:  d = 8'h7E;  7'd87:  d = 8'h00;
            7'd88:  d = 8'hC3;  7'd89:  d = 8'h66;  7'd90:  d = 8'hDB;  7'd91:  d = 8'hDB;
            7'd92:  d = 8'h7E;  7'd93:  d = 8'h3C;  7'd94:  d = 8'h24;  7'd95:  d = 8'h00;
            7'd96:  d = 8'hC3;  7'd97:  d = 8'hE7;  7'd98:  d = 8'h7E;  7'd99:  d = 8'h5A;
            7'd100: d = 8'h7E;  7'd101: d = 8'h3C;  7'd102: d = 8'h18;  7'd103: d = 8'h00;
            7'd104: d = 8'h00;  7'd105: d = 8'h3C;  7'd106: d = 8'h7E;  7'd107: d = 8'hFF;
            7'd108: d = 8'hFF;  7'd109: d = 8'h7E;  7'd110: d = 8'h5A;  7'd111: d = 8'h00;
            7'd112, 7'd113, 7'd114, 7'd115,
            7'd116, 7'd117, 7'd118, 7'd119: d = 8'hFF;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

`ifdef DZ_BLINK_EN
    logic [4:0] blink_q, blink_d;
    logic       frame_wrap;

    assign frame_wrap = (state_q == S_SCAN) && st && (presc_q == PRESC_TC) && (rowcnt_q == 3'd7);
    assign blink_d    = frame_wrap ? blink_q + 5'd1 : blink_q;
    assign cols_off   = fail & blink_d[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 5'd0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    assign cols_off = 1'b0;
`endif

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= 16'd0;
            rowcnt_q   <= 3'd0;
            cur_img_q  <= 4'd15;
            pend_img_q <= 4'd15;
            row_q      <= 8'hFF;
            colg_q     <= 8'h00;
            colr_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            rowcnt_q   <= rowcnt_d;
            cur_img_q  <= cur_img_d;
            pend_img_q <= pend_img_d;
            row_q      <= row_d;
            colg_q     <= colg_d;
            colr_q     <= colr_d;
        end
    end

    // A new image is only committed at frame start so a frame is never torn.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        rowcnt_d   = rowcnt_q;
        cur_img_d  = cur_img_q;
        pend_img_d = ld ? num : pend_img_q;
        unique case (state_q)
            S_IDLE: begin
                presc_d  = 16'd0;
                rowcnt_d = 3'd0;
                if (st) begin
                    state_d   = S_SCAN;
                    cur_img_d = pend_img_d;
                end
            end
            S_SCAN: begin
                if (!st) begin
                    state_d  = S_IDLE;
                    presc_d  = 16'd0;
                    rowcnt_d = 3'd0;
                end else if (presc_q == PRESC_TC) begin
                    presc_d  = 16'd0;
                    rowcnt_d = rowcnt_q + 3'd1;
                    if (rowcnt_q == 3'd7) begin
                        cur_img_d = pend_img_d;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d    = 8'hFF;
        colg_d   = 8'h00;
        colr_d   = 8'h00;
        rom_data = img_rom({cur_img_d, rowcnt_d});
        if ((state_d == S_SCAN) && (presc_d != 16'd0)) begin
            row_d = ~(8'd1 << rowcnt_d);
            if (!cols_off) begin
                if (fail) begin
                    colg_d = rom_data;
                end else begin
                    colr_d = rom_data;
                end
            end
        end
    end

    assign row  = row_q;
    assign colg = colg_q;
    assign colr = colr_q;

endmodule

// File: tb/tb_dz_scan.sv
// Scoreboard bench for dz_scan at SCAN_DIV=4; a behavioural model pushes the expected
// {row,colg,colr} each cycle and the value is popped and checked one edge later.
module tb_dz_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, st, ld, fail;
    logic [3:0] num;
    logic [7:0] row, colg, colr;

    int checks = 0;
    int errors = 0;

    logic [23:0] sb_q[$];

    bit         m_scan;
    int         m_presc, m_row;
    logic [3:0] m_cur, m_pend;
    logic [4:0] m_blink;

    always #5 clk = ~clk;

    dz_scan #(.SCAN_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .st  (st),
        .ld  (ld),
        .num (num),
        .fail(fail),
        .row (row),
        .colg(colg),
        .colr(colr)
    );

    function automatic logic [7:0] img_byte(input logic [3:0] img);
        return (img == 4'd14) ? 8'hFF : 8'h00;
    endfunction

    task automatic model_push();
        logic [3:0]  nl;
        logic [7:0]  d;
        logic [23:0] e;
        bit          off;
        e = {8'hFF, 16'h0000};
        if (rst) begin
            m_scan = 0; m_presc = 0; m_row = 0;
            m_cur = 4'd15; m_pend = 4'd15; m_blink = 5'd0;
        end else begin
            nl = ld ? num : m_pend;
            if (!m_scan) begin
                m_presc = 0; m_row = 0;
                if (st) begin
                    m_scan = 1; m_cur = nl;
                end
            end else if (!st) begin
                m_scan = 0; m_presc = 0; m_row = 0;
            end else if (m_presc == DIV - 1) begin
                m_presc = 0;
                if (m_row == 7) begin
                    m_row = 0; m_cur = nl; m_blink = m_blink + 5'd1;
                end else begin
                    m_row = m_row + 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
            m_pend = nl;
            if (m_scan && m_presc != 0) begin
                d   = img_byte(m_cur);
                off = 0;
`ifdef DZ_BLINK_EN
                off = fail && m_blink[4];
`endif
                e[23:16] = ~(8'd1 << m_row);
                if (!off) begin
                    if (fail) e[15:8] = d;
                    else      e[7:0]  = d;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic step(input string tag, input int n);
        logic [23:0] exp_v;
        for (int i = 0; i < n; i++) begin
            model_push();
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            checks++;
            assert ({row, colg, colr} === exp_v) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", tag, {row, colg, colr}, exp_v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] exp_v);
        checks++;
        assert ({row, colg, colr} === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, {row, colg, colr}, exp_v);
        end
    endtask

    // Advance until the model sits at the given row/prescaler position.
    task automatic run_until(input int r, input int p);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_scan && m_row == r && m_presc == p) begin
                hit = 1;
                break;
            end
            step("run", 1);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL run_until obs=timeout exp=row%0d/presc%0d", r, p);
        end
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; ld = 1'b0; num = 4'd0; fail = 1'b0;
        m_scan = 0; m_presc = 0; m_row = 0; m_cur = 4'd15; m_pend = 4'd15; m_blink = 5'd0;

        step("reset", 2);
        chk("reset_out", {8'hFF, 16'h0000});
        rst = 1'b0;
        step("idle", 20);
        chk("idle_out", {8'hFF, 16'h0000});

        ld = 1'b1; num = 4'd14;
        step("ld_idle", 1);
        ld = 1'b0;
        st = 1'b1;
        step("entry", 1);
        chk("entry_blank", {8'hFF, 16'h0000});
        step("row0", 1);
        chk("row0_red", {8'hFE, 8'h00, 8'hFF});
        step("scan14", 64);

        run_until(3, 1);
        ld = 1'b1; num = 4'd15;
        step("ld_mid", 1);
        ld = 1'b0;
        run_until(7, 3);
        chk("row7_held", {8'h7F, 8'h00, 8'hFF});
        step("wrap15", 2);
        chk("img15_row0", {8'hFE, 8'h00, 8'h00});

        run_until(7, 3);
        ld = 1'b1; num = 4'd14;
        step("ld_wrap", 1);
        ld = 1'b0;
        chk("wrap_blank", {8'hFF, 16'h0000});
        step("wrap_row0", 1);
        chk("ld_at_wrap", {8'hFE, 8'h00, 8'hFF});

        fail = 1'b1;
        step("fail_green", 1);
        chk("green", {8'hFE, 8'hFF, 8'h00});
        step("blink", 48 * 8 * DIV);
        fail = 1'b0;
        step("red_again", 4);

        run_until(5, 2);
        st = 1'b0;
        step("st_drop", 1);
        chk("st_drop_blank", {8'hFF, 16'h0000});
        step("idle2", 3);
        st = 1'b1;
        step("reentry", 1);
        chk("reentry_blank", {8'hFF, 16'h0000});
        step("reentry_row0", 1);
        chk("reentry_row0", {8'hFE, 8'h00, 8'hFF});

        run_until(4, 2);
        rst = 1'b1; ld = 1'b1; num = 4'd3;
        step("rst_mid", 1);
        chk("rst_mid_blank", {8'hFF, 16'h0000});
        rst = 1'b0; ld = 1'b0;
        step("post_rst_entry", 1);
        step("post_rst_row0", 1);
        chk("rst_beats_ld", {8'hFE, 8'h00, 8'h00});
        step("tail", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
